// File: rtl/dm_arbiter.sv
// Round-robin arbiter that serialises NUM_CORES cores onto one single-port
// data memory. Writes take one grant cycle plus one turnaround cycle.
// Reads take an address cycle, a data cycle, the grant cycle and one
// turnaround cycle. The block also registers the AND of all core_done flags.
`timescale 1ns/1ps

module dm_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          we,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  input  logic [NUM_CORES-1:0]          core_done,
  output logic [NUM_CORES-1:0]          gnt,
  output logic [NUM_CORES-1:0]          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy,
  output logic                          all_done
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     sel_q, sel_d;
  logic [NUM_CORES-1:0] gnt_d, rvalid_d;
  logic [DATA_W-1:0]    rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0]    mem_addr_d;
  logic                 mem_we_d;

  logic [PTR_W-1:0]     win_idx;
  logic                 win_found;

  logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
  logic [DATA_W-1:0]    wdata_arr [NUM_CORES];

  // Unpack the flat per-core buses so that the winner can be indexed directly.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
  end

  // Busy is the only combinational output. It is low only in IDLE.
  assign busy = (state_q != IDLE);

  // Round-robin pick: the first requester at or after rr_ptr, with wrap-around.
  always_comb begin : p_pick
    logic [PTR_W:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_CORES)) begin
        cand = cand - (PTR_W+1)'(NUM_CORES);
      end
      if (!win_found && req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_we_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          sel_d       = win_idx;
          mem_addr_d  = addr_arr[win_idx];
          mem_wdata_d = wdata_arr[win_idx];
          rr_ptr_d    = (win_idx == PTR_W'(NUM_CORES-1)) ? '0 : win_idx + PTR_W'(1);
          if (we[win_idx]) begin
            mem_we_d       = 1'b1;
            gnt_d[win_idx] = 1'b1;
            state_d        = WR;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      // The memory commits the write on the edge that leaves WR.
      WR:      state_d = IDLE;
      // The memory captures the held address here. Its data appears next cycle.
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        rdata_d         = mem_rdata;
        gnt_d[sel_q]    = 1'b1;
        rvalid_d[sel_q] = 1'b1;
        state_d         = RELEASE;
      end
      // The grant cycle ends here. Requests are not sampled so the core can
      // drop or renew req.
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register the FSM state, the round-robin pointer and all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Reset is synchronous, so it is the first branch inside the clocked block.
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      gnt       <= gnt_d;
      rvalid    <= rvalid_d;
      rdata     <= rdata_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
    end
  end

  // all_done follows the cores' end_process flags one cycle later. It does not
  // depend on the arbitration state.
  always_ff @(posedge clk) begin
    if (rst) all_done <= 1'b0;
    else     all_done <= &core_done;
  end

endmodule
